// File: rtl/seq_multiplier_wb.sv
// rtl/seq_multiplier_wb.sv - multi-cycle 16x16 shift-add multiplier writing its product back to the register bank
module seq_multiplier_wb #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [REG_AW-1:0] dest_sel,
  input  logic              hi_en,
  output logic              busy,
  output logic              done,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_sel,
  output logic [DATA_W-1:0] wr_data
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    WB_LO = 2'd2,
    WB_HI = 2'd3
  } state_t;

  state_t              state_q;
  logic [PROD_W-1:0]   acc_q;
  logic [PROD_W-1:0]   acc_d;
  logic [PROD_W-1:0]   mcand_q;
  logic [DATA_W-1:0]   mplr_q;
  logic [CNT_W-1:0]    count_q;
  logic [REG_AW-1:0]   dest_q;
  logic                hi_en_q;
  logic                busy_q;
  logic                done_q;
  logic                wr_en_q;
  logic [REG_AW-1:0]   wr_sel_q;
  logic [DATA_W-1:0]   wr_data_q;

  // The final CALC cycle's add is folded into acc_d so the low word is ready for WB_LO.
  always_comb begin
    acc_d = acc_q;
    if (mplr_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      count_q   <= '0;
      dest_q    <= '0;
      hi_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_sel_q  <= '0;
      wr_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q <= PROD_W'(op_a);
            mplr_q  <= op_b;
            dest_q  <= dest_sel;
            hi_en_q <= hi_en;
            acc_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q   <= acc_d;
          mcand_q <= mcand_q << 1;
          mplr_q  <= mplr_q >> 1;
          count_q <= count_q + CNT_W'(1);
          if (count_q == CNT_W'(DATA_W - 1)) begin
            state_q   <= WB_LO;
            wr_en_q   <= 1'b1;
            wr_sel_q  <= dest_q;
            wr_data_q <= acc_d[DATA_W-1:0];
            done_q    <= !hi_en_q;
          end
        end
        WB_LO: begin
          if (hi_en_q) begin
            state_q   <= WB_HI;
            wr_sel_q  <= dest_q + REG_AW'(1);
            wr_data_q <= acc_q[PROD_W-1:DATA_W];
            done_q    <= 1'b1;
          end else begin
            state_q <= IDLE;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        WB_HI: begin
          state_q <= IDLE;
          wr_en_q <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          wr_en_q <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign wr_en   = wr_en_q;
  assign wr_sel  = wr_sel_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_seq_multiplier_wb.sv
// tb/tb_seq_multiplier_wb.sv - directed self-checking bench for seq_multiplier_wb
module tb_seq_multiplier_wb;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [2:0]  dest_sel;
  logic        hi_en;
  logic        busy;
  logic        done;
  logic        wr_en;
  logic [2:0]  wr_sel;
  logic [15:0] wr_data;

  logic [15:0] bank [8];
  logic [15:0] snap [8];
  int          wr_cnt;
  int          n_tests;
  int          n_fail;

  seq_multiplier_wb #(.DATA_W(16), .REG_AW(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .dest_sel(dest_sel), .hi_en(hi_en), .busy(busy), .done(done),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register bank model: captures the write port on the edge ending each WB cycle.
  always @(posedge clk) begin
    if (wr_en === 1'b1) begin
      bank[wr_sel] <= wr_data;
      wr_cnt       <= wr_cnt + 1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " busy"},    32'(busy),    32'd0);
    chk({tag, " done"},    32'(done),    32'd0);
    chk({tag, " wr_en"},   32'(wr_en),   32'd0);
    chk({tag, " wr_sel"},  32'(wr_sel),  32'd0);
    chk({tag, " wr_data"}, 32'(wr_data), 32'd0);
  endtask

  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] dest, input logic hi, input logic [15:0] lo_exp,
                        input logic [15:0] hi_exp, input logic scramble);
    logic [2:0] nx;
    int         w0;
    nx       = dest + 3'd1;
    w0       = wr_cnt;
    op_a     = a;
    op_b     = b;
    dest_sel = dest;
    hi_en    = hi;
    start    = 1'b1;
    tick;
    start = 1'b0;
    chk({name, " busy after accept"}, 32'(busy), 32'd1);
    for (int i = 1; i < 16; i++) begin
      if (scramble) begin
        op_a     = 16'($urandom);
        op_b     = 16'($urandom);
        dest_sel = 3'($urandom_range(7, 0));
        hi_en    = 1'($urandom_range(1, 0));
      end
      tick;
    end
    chk({name, " cyc16 wr_en"}, 32'(wr_en), 32'd0);
    chk({name, " cyc16 busy"},  32'(busy),  32'd1);
    tick;
    chk({name, " lo wr_en"},   32'(wr_en),   32'd1);
    chk({name, " lo wr_sel"},  32'(wr_sel),  32'(dest));
    chk({name, " lo wr_data"}, 32'(wr_data), 32'(lo_exp));
    chk({name, " lo done"},    32'(done),    32'(!hi));
    if (hi) begin
      tick;
      chk({name, " hi wr_en"},   32'(wr_en),   32'd1);
      chk({name, " hi wr_sel"},  32'(wr_sel),  32'(nx));
      chk({name, " hi wr_data"}, 32'(wr_data), 32'(hi_exp));
      chk({name, " hi done"},    32'(done),    32'd1);
    end
    tick;
    chk({name, " end busy"},  32'(busy),  32'd0);
    chk({name, " end wr_en"}, 32'(wr_en), 32'd0);
    chk({name, " end done"},  32'(done),  32'd0);
    chk({name, " bank lo"},   32'(bank[dest]), 32'(lo_exp));
    if (hi) begin
      chk({name, " bank hi"}, 32'(bank[nx]), 32'(hi_exp));
    end
    chk({name, " write count"}, 32'(wr_cnt - w0), hi ? 32'd2 : 32'd1);
  endtask

  initial begin
    int w0;
    n_tests  = 0;
    n_fail   = 0;
    wr_cnt   = 0;
    for (int i = 0; i < 8; i++) bank[i] = 16'h0;
    rst_n    = 1'b0;
    start    = 1'b0;
    op_a     = '0;
    op_b     = '0;
    dest_sel = '0;
    hi_en    = 1'b0;
    tick;
    tick;
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    tick;
    chk_idle_outputs("post-reset idle");

    run_op("basic",   16'h0003, 16'h0005, 3'd2, 1'b1, 16'h000F, 16'h0000, 1'b0);
    run_op("max",     16'hFFFF, 16'hFFFF, 3'd4, 1'b1, 16'h0001, 16'hFFFE, 1'b0);
    run_op("shift",   16'h1234, 16'h0010, 3'd0, 1'b1, 16'h2340, 16'h0001, 1'b0);
    run_op("wrap",    16'h0100, 16'h0100, 3'd7, 1'b1, 16'h0000, 16'h0001, 1'b0);
    run_op("lo-only", 16'h00FF, 16'h0002, 3'd7, 1'b0, 16'h01FE, 16'h0000, 1'b0);
    chk("lo-only r0 untouched", 32'(bank[0]), 32'h0001);

    // A second start at cycle 5 must be dropped without disturbing the latched operands.
    w0       = wr_cnt;
    op_a     = 16'h0007;
    op_b     = 16'h0009;
    dest_sel = 3'd5;
    hi_en    = 1'b1;
    start    = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 1; i < 5; i++) tick;
    op_a     = 16'hAAAA;
    op_b     = 16'h5555;
    dest_sel = 3'd1;
    hi_en    = 1'b0;
    start    = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 6; i < 17; i++) tick;
    chk("busy-start lo wr_sel",  32'(wr_sel),  32'd5);
    chk("busy-start lo wr_data", 32'(wr_data), 32'h003F);
    tick;
    chk("busy-start hi wr_sel",  32'(wr_sel),  32'd6);
    chk("busy-start hi wr_data", 32'(wr_data), 32'h0000);
    chk("busy-start hi done",    32'(done),    32'd1);
    tick;
    chk("busy-start write count", 32'(wr_cnt - w0), 32'd2);
    chk("busy-start bank r5",     32'(bank[5]),     32'h003F);
    run_op("after-done", 16'h0011, 16'h0011, 3'd6, 1'b0, 16'h0121, 16'h0000, 1'b0);

    for (int i = 0; i < 8; i++) snap[i] = bank[i];
    w0       = wr_cnt;
    op_a     = 16'h4321;
    op_b     = 16'h0F0F;
    dest_sel = 3'd3;
    hi_en    = 1'b1;
    start    = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 1; i < 9; i++) tick;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("mid-calc reset");
    tick;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) tick;
    chk("mid-calc reset no write", 32'(wr_cnt - w0), 32'd0);
    chk("mid-calc reset busy",     32'(busy),        32'd0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("mid-calc reset bank r%0d", i), 32'(bank[i]), 32'(snap[i]));
    end
    run_op("post-abort", 16'h0002, 16'h0003, 3'd1, 1'b0, 16'h0006, 16'h0000, 1'b0);

    run_op("operand hold", 16'h0123, 16'h0456, 3'd3, 1'b1, 16'hEDC2, 16'h0004, 1'b1);
    run_op("zero operand", 16'h0000, 16'h1234, 3'd2, 1'b0, 16'h0000, 16'h0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_multiplier_wb.md
Name: seq_multiplier_wb

Overview:
- Multi-cycle unsigned 16x16 shift-add multiplier that sits downstream of the 8x16 register bank.
- Consumes the two register-bank read ports as operands.
- Writes the 32-bit product back through the bank's single write port.
- Low word goes to the destination register; the high word optionally goes to the next register.

Parameters:
- DATA_W, 16, operand and register width; product is 2*DATA_W.
- REG_AW, 3, register select width (8 registers).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- op_a  input  DATA_W  multiplicand, taken from register-bank read port 1.
- op_b  input  DATA_W  multiplier, taken from register-bank read port 2.
- dest_sel  input  REG_AW  destination register for the low product word.
- hi_en  input  1  when 1, the high product word is also written to dest_sel+1 (mod 8).
- busy  output  1  high from the cycle after start is accepted until return to IDLE.
- done  output  1  single-cycle pulse in the final write-back cycle.
- wr_en  output  1  drives the register-bank write enable.
- wr_sel  output  REG_AW  drives the register-bank write select.
- wr_data  output  DATA_W  drives the register-bank write data.

Behaviour:
- Reset (async assert of rst_n low, any state):
  - state=IDLE.
  - busy=0, done=0, wr_en=0, wr_sel=0, wr_data=0.
  - Internal accumulator, multiplicand, multiplier, count, latched dest and latched hi_en all 0.
- All outputs are registered or decoded only from state and flops; there is no combinational path from inputs to outputs.
- IDLE:
  - If start=1 at a rising edge: latch op_a, op_b, dest_sel and hi_en; clear the 32-bit accumulator; count=0; go to CALC.
  - Otherwise remain in IDLE.
  - Operands are sampled only on that one edge; later changes on op_a/op_b are ignored.
- CALC (exactly 16 cycles, count 0..15):
  - If multiplier bit0=1, accumulator += multiplicand (zero-extended to 32 bits, aligned to the current shift).
  - Then shift the multiplicand left 1 and the multiplier right 1; count++.
  - After the cycle with count=15, go to WB_LO.
  - Fixed latency: no early exit when an operand is zero.
- WB_LO (1 cycle):
  - wr_en=1, wr_sel=latched dest, wr_data=product[15:0].
  - If latched hi_en=1, go to WB_HI. Otherwise done=1 this cycle and return to IDLE.
- WB_HI (1 cycle):
  - wr_en=1, wr_sel=(latched dest+1) mod 8 (7 wraps to 0), wr_data=product[31:16], done=1.
  - Return to IDLE.
- Latency, counting the start-accept edge as edge 0:
  - Cycles 1-16 are CALC.
  - WB_LO is cycle 17.
  - WB_HI is cycle 18.
  - The next start is accepted at the edge ending the final WB cycle only if the FSM is already back in IDLE. Hence the first new accept is the edge after done.
- busy=1 in CALC, WB_LO and WB_HI; 0 in IDLE.
- start while busy is ignored entirely: no queuing, no latch update.
- wr_en=0 in IDLE and CALC; wr_sel and wr_data hold their last values while wr_en=0.
- The register-bank write occurs on the rising edge that ends each WB cycle.
- The upstream controller must not drive the bank's write port while busy=1; the block does not arbitrate.
- Arithmetic:
  - Unsigned only; the product is exact, with no overflow possible in 32 bits.
  - Accumulator adds are 32-bit; carries out of bit 31 cannot occur.
- Reset mid-operation: immediate abort; no partial write is issued; after rst_n deasserts the block is in IDLE and accepts start on the first edge.
- dest_sel=7 with hi_en=1 writes the low word to r7 and the high word to r0.

Test Plan:
- Basic multiply: op_a=0x0003, op_b=0x0005, dest_sel=2, hi_en=1, start pulse -> busy for 18 cycles. Cycle 17: wr_en=1, wr_sel=2, wr_data=0x000F. Cycle 18: wr_sel=3, wr_data=0x0000, done=1. Bank r2=0x000F, r3=0x0000.
- Max operands: op_a=0xFFFF, op_b=0xFFFF, dest_sel=4, hi_en=1 -> writes r4=0x0001 then r5=0xFFFE. A 0x1234*0x0010 run with dest_sel=0, hi_en=1 -> r0=0x2340, r1=0x0001.
- Wrap and low-only:
  - dest_sel=7, hi_en=1, 0x0100*0x0100 -> r7=0x0000, r0=0x0001.
  - hi_en=0, 0x00FF*0x0002 -> a single write r7=0x01FE; done at cycle 17; r0 unchanged.
- Start while busy: second start at cycle 5 with different operands -> ignored; the original product is written; exactly 2 wr_en cycles. A start issued the cycle after done is accepted.
- Reset mid-CALC: assert rst_n=0 at cycle 9 -> all outputs 0 immediately; no wr_en pulse; bank contents unchanged. A new 0x0002*0x0003 run after release produces 0x0006 normally.
- Operand hold: change op_a/op_b every cycle during CALC -> result reflects the values sampled at the start edge only. A zero operand still takes the full 16-cycle latency and writes 0x0000.
